fuel_pump_guard: RTL and testbench
==================================

FUEL_PUMP_GUARD -- requirements
Module: fuel_pump_guard

Parameters
REQ-001 The block SHALL have parameter SW_W, default 4, giving the hidden switch bus width (1..16).
REQ-002 The block SHALL have parameter SECRET, default 4'hA (SW_W bits), giving the hidden switch code that enables fuel.
REQ-003 The block SHALL have parameter GRACE_CYC, default 8, giving the cycles fuel stays on after a code loss while running (1..65535).
REQ-004 The block SHALL have parameter MAX_TRIES, default 3, giving the failed attempts that trigger lockout (1..15).
REQ-005 The block SHALL have parameter LOCK_CYC, default 16, giving the lockout duration in cycles (1..65535).

Interface
REQ-006 clock  in  1  system clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 ignition  in  1  key in RUN position.
REQ-009 brake  in  1  brake pedal pressed.
REQ-010 hidden_sw  in  SW_W  hidden switch bank.
REQ-011 fuel_pump  out  1  pump enable.
REQ-012 alarm  out  1  high only in LOCKOUT.
REQ-013 state  out  3  current state encoding.
REQ-014 fail_count  out  4  failed attempts since last clear.

Function
REQ-015 The FSM SHALL use states IDLE=0, IGN_ON=1, FUEL_ON=2, GRACE=3, LOCKOUT=4; encodings 5-7 SHALL go to IDLE on the next edge.
REQ-016 Outputs SHALL be Moore: fuel_pump=1 iff state is FUEL_ON or GRACE; alarm=1 iff state is LOCKOUT; one-cycle latency from the qualifying input to output.
REQ-017 match SHALL be defined as (hidden_sw == SECRET); brake_rise SHALL be brake & ~brake_q, where brake_q is brake registered (reset 0).
REQ-018 IDLE: ignition -> IGN_ON; else stay.
REQ-019 IGN_ON, in priority order: ~ignition -> IDLE; brake & match -> FUEL_ON, fail_count cleared; brake_rise & ~match -> fail_count+1, and -> LOCKOUT if the new count equals MAX_TRIES; else stay.
REQ-020 FUEL_ON: ~ignition -> IDLE; ~match -> GRACE, grace timer loaded with GRACE_CYC-1; else stay. Brake is ignored once fuel is on.
REQ-021 GRACE: ~ignition -> IDLE; match -> FUEL_ON; timer==0 -> IDLE; else timer-1.
REQ-022 LOCKOUT: the timer SHALL be loaded with LOCK_CYC-1 on entry; ignition, brake and hidden_sw SHALL be ignored; at timer==0 -> IDLE with fail_count cleared.
REQ-023 fail_count SHALL saturate at MAX_TRIES and SHALL NOT wrap.
REQ-024 fail_count SHALL persist across ignition cycles (IGN_ON -> IDLE -> IGN_ON) and SHALL clear only on FUEL_ON entry, lockout expiry, or reset.
REQ-025 A single 16-bit down-counter MAY be shared by GRACE and LOCKOUT; it SHALL never underflow.
REQ-026 brake_rise coinciding with ~ignition SHALL NOT count as an attempt, because ~ignition has priority.

Reset
REQ-027 Reset SHALL force state=IDLE, fuel_pump=0, alarm=0, fail_count=0, timer=0 and brake_q=0 asynchronously, including mid-GRACE and mid-LOCKOUT.
REQ-028 After reset deassertion, the first transition SHALL occur on the next rising clock edge.

Verification (defaults)
REQ-029 ignition=1, hidden_sw=4'hA, then brake=1 -> state 1, then 2; fuel_pump=1 one cycle after the brake edge; fail_count=0.
REQ-030 Running with fuel on, hidden_sw->4'h0 for 5 cycles then back to 4'hA -> fuel_pump stays 1 throughout; state 3, then 2.
REQ-031 Running with fuel on, hidden_sw->4'h0 held -> fuel_pump=1 for exactly 8 cycles in GRACE, then state 0 and fuel_pump=0.
REQ-032 ignition=1, hidden_sw=4'h5, three brake pulses -> fail_count 1, 2, 3; state 4; alarm=1 for 16 cycles; then state 0, alarm=0, fail_count=0; a correct code during lockout has no effect.
REQ-033 Two failed pulses, ignition off then on, third failed pulse -> LOCKOUT (fail_count persisted at 2).
REQ-034 Reset asserted mid-GRACE or mid-LOCKOUT -> immediately fuel_pump=0, alarm=0, state 0, fail_count=0.

Source files
------------

// File: rtl/fuel_pump_guard.sv
// Anti-theft fuel pump interlock: fuel only after the brake is pressed with the secret switch code.
// Latency: Moore outputs, one clock from the qualifying input to fuel_pump/alarm/state.
// Backpressure: none; inputs are sampled every cycle and LOCKOUT ignores all driver inputs.
module fuel_pump_guard #(
    parameter int              SW_W      = 4,
    parameter logic [SW_W-1:0] SECRET    = 4'hA,
    parameter int              GRACE_CYC = 8,
    parameter int              MAX_TRIES = 3,
    parameter int              LOCK_CYC  = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ignition,
    input  logic            brake,
    input  logic [SW_W-1:0] hidden_sw,
    output logic            fuel_pump,
    output logic            alarm,
    output logic [2:0]      state,
    output logic [3:0]      fail_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IGN_ON  = 3'd1,
        FUEL_ON = 3'd2,
        GRACE   = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    // Timer reload values; the shared counter counts down to zero inclusive,
    // so loading N-1 gives exactly N cycles in GRACE or LOCKOUT.
    localparam logic [15:0] GRACE_LD = 16'(GRACE_CYC - 1);
    localparam logic [15:0] LOCK_LD  = 16'(LOCK_CYC - 1);
    localparam logic [3:0]  MAX_T    = 4'(MAX_TRIES);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  fail_q, fail_d;
    logic        brake_q, brake_d;

    logic        match;
    logic        brake_rise;
    logic [3:0]  fail_inc;

    assign match      = (hidden_sw == SECRET);
    assign brake_rise = brake & ~brake_q;

    // Next-state, timer and attempt-counter logic; ~ignition always wins in driving states.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        fail_d   = fail_q;
        brake_d  = brake;
        fail_inc = (fail_q >= MAX_T) ? MAX_T : fail_q + 4'd1;
        case (state_q)
            IDLE: begin
                if (ignition) begin
                    state_d = IGN_ON;
                end
            end
            IGN_ON: begin
                if (!ignition) begin
                    state_d = IDLE;
                end else if (brake && match) begin
                    state_d = FUEL_ON;
                    fail_d  = 4'd0;
                end else if (brake_rise && !match) begin
                    // Only a fresh brake press counts as an attempt; holding it does not.
                    fail_d = fail_inc;
                    if (fail_inc == MAX_T) begin
                        state_d = LOCKOUT;
                        timer_d = LOCK_LD;
                    end
                end
            end
            FUEL_ON: begin
                if (!ignition) begin
                    state_d = IDLE;
                end else if (!match) begin
                    state_d = GRACE;
                    timer_d = GRACE_LD;
                end
            end
            GRACE: begin
                if (!ignition) begin
                    state_d = IDLE;
                end else if (match) begin
                    state_d = FUEL_ON;
                end else if (timer_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            LOCKOUT: begin
                if (timer_q == 16'd0) begin
                    state_d = IDLE;
                    fail_d  = 4'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, timer, attempt counter and brake history registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= 16'd0;
            fail_q  <= 4'd0;
            brake_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            brake_q <= brake_d;
        end
    end

    assign fuel_pump  = (state_q == FUEL_ON) || (state_q == GRACE);
    assign alarm      = (state_q == LOCKOUT);
    assign state      = state_q;
    assign fail_count = fail_q;

endmodule

// File: tb/tb_fuel_pump_guard.sv
// Bench for fuel_pump_guard with default parameters.
// Vectors are driven on the falling edge and their expectations queued; a
// checker pops and compares one record per rising edge.
module tb_fuel_pump_guard;

    logic       clock;
    logic       reset;
    logic       ignition;
    logic       brake;
    logic [3:0] hidden_sw;
    logic       fuel_pump;
    logic       alarm;
    logic [2:0] state;
    logic [3:0] fail_count;

    fuel_pump_guard dut (
        .clock      (clock),
        .reset      (reset),
        .ignition   (ignition),
        .brake      (brake),
        .hidden_sw  (hidden_sw),
        .fuel_pump  (fuel_pump),
        .alarm      (alarm),
        .state      (state),
        .fail_count (fail_count)
    );

    typedef struct {
        logic       ign;
        logic       brk;
        logic [3:0] sw;
        logic [2:0] st;
        logic       fuel;
        logic       alm;
        logic [3:0] fc;
    } vec_t;

    typedef struct {
        int         id;
        logic [2:0] st;
        logic       fuel;
        logic       alm;
        logic [3:0] fc;
    } exp_t;

    localparam logic [3:0] A = 4'hA;
    localparam logic [3:0] Z = 4'h0;
    localparam logic [3:0] F = 4'h5;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void add(input logic i, input logic b, input logic [3:0] sw,
                                input logic [2:0] st, input logic fu, input logic al,
                                input logic [3:0] fc);
        vec_t v;
        v.ign = i; v.brk = b; v.sw = sw; v.st = st; v.fuel = fu; v.alm = al; v.fc = fc;
        tbl.push_back(v);
    endfunction

    task automatic step(input logic i, input logic b, input logic [3:0] sw,
                        input logic [2:0] st, input logic fu, input logic al,
                        input logic [3:0] fc);
        exp_t e;
        @(negedge clock);
        ignition  = i;
        brake     = b;
        hidden_sw = sw;
        e.id = vec_id; e.st = st; e.fuel = fu; e.alm = al; e.fc = fc;
        vec_id++;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [2:0] st, input logic fu,
                             input logic al, input logic [3:0] fc);
        checks++;
        if (state !== st || fuel_pump !== fu || alarm !== al || fail_count !== fc) begin
            errors++;
            $display("FAIL %s: got st=%0d fuel=%b alarm=%b fc=%0d, want st=%0d fuel=%b alarm=%b fc=%0d",
                     name, state, fuel_pump, alarm, fail_count, st, fu, al, fc);
        end
    endtask

    // Wait (bounded) until the checker has consumed every queued expectation.
    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard: compare DUT outputs one time unit after each rising edge.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (state !== e.st || fuel_pump !== e.fuel || alarm !== e.alm || fail_count !== e.fc) begin
                errors++;
                $display("FAIL vec%0d: got st=%0d fuel=%b alarm=%b fc=%0d, want st=%0d fuel=%b alarm=%b fc=%0d",
                         e.id, state, fuel_pump, alarm, fail_count, e.st, e.fuel, e.alm, e.fc);
            end
        end
    end

    initial begin
        exp_t e;
        reset     = 1'b1;
        ignition  = 1'b0;
        brake     = 1'b0;
        hidden_sw = Z;

        // Start, fuel enable, and grace recovery after a short code loss.
        add(0, 0, A, 0, 0, 0, 0);
        add(1, 0, A, 1, 0, 0, 0);
        add(1, 1, A, 2, 1, 0, 0);
        add(1, 1, A, 2, 1, 0, 0);
        add(1, 0, A, 2, 1, 0, 0);
        for (int k = 0; k < 5; k++) add(1, 0, Z, 3, 1, 0, 0);
        add(1, 0, A, 2, 1, 0, 0);
        // Code lost and held: exactly 8 cycles of GRACE, then IDLE.
        for (int k = 0; k < 8; k++) add(1, 1, Z, 3, 1, 0, 0);
        add(1, 1, Z, 0, 0, 0, 0);
        // Wrong code attempts persisting across an ignition cycle.
        add(1, 0, F, 1, 0, 0, 0);
        add(1, 1, F, 1, 0, 0, 1);
        add(1, 0, F, 1, 0, 0, 1);
        add(1, 1, F, 1, 0, 0, 2);
        add(1, 0, F, 1, 0, 0, 2);
        add(0, 0, F, 0, 0, 0, 2);
        add(1, 0, F, 1, 0, 0, 2);
        add(0, 1, F, 0, 0, 0, 2);
        add(1, 1, F, 1, 0, 0, 2);
        add(1, 1, F, 1, 0, 0, 2);
        add(1, 0, F, 1, 0, 0, 2);
        add(1, 1, F, 4, 0, 1, 3);
        // Lockout ignores the correct code and brake; alarm for 16 cycles total.
        for (int k = 0; k < 15; k++) add(1, 1'(k % 2), A, 4, 0, 1, 3);
        add(0, 0, A, 0, 0, 0, 0);
        // A failed attempt is cleared when fuel comes on.
        add(1, 0, F, 1, 0, 0, 0);
        add(1, 1, F, 1, 0, 0, 1);
        add(1, 1, A, 2, 1, 0, 0);
        add(1, 0, Z, 3, 1, 0, 0);
        add(0, 0, Z, 0, 0, 0, 0);

        #2;
        check_now("reset_state", 3'd0, 1'b0, 1'b0, 4'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int n = 0; n < tbl.size(); n++)
            step(tbl[n].ign, tbl[n].brk, tbl[n].sw, tbl[n].st, tbl[n].fuel, tbl[n].alm, tbl[n].fc);
        drain();

        // Reset asserted in the middle of GRACE.
        step(1, 1, A, 1, 0, 0, 0);
        step(1, 1, A, 2, 1, 0, 0);
        step(1, 0, Z, 3, 1, 0, 0);
        step(1, 0, Z, 3, 1, 0, 0);
        drain();
        reset = 1'b1;
        #1;
        check_now("reset_mid_grace", 3'd0, 1'b0, 1'b0, 4'd0);

        // First transition happens on the first edge after release.
        @(negedge clock);
        reset     = 1'b0;
        ignition  = 1'b1;
        brake     = 1'b0;
        hidden_sw = F;
        e.id = vec_id; e.st = 3'd1; e.fuel = 1'b0; e.alm = 1'b0; e.fc = 4'd0;
        vec_id++;
        exp_q.push_back(e);

        // Reset asserted in the middle of LOCKOUT.
        step(1, 1, F, 1, 0, 0, 1);
        step(1, 0, F, 1, 0, 0, 1);
        step(1, 1, F, 1, 0, 0, 2);
        step(1, 0, F, 1, 0, 0, 2);
        step(1, 1, F, 4, 0, 1, 3);
        step(0, 0, F, 4, 0, 1, 3);
        step(0, 0, F, 4, 0, 1, 3);
        drain();
        reset = 1'b1;
        #1;
        check_now("reset_mid_lockout", 3'd0, 1'b0, 1'b0, 4'd0);
        @(negedge clock);
        check_now("reset_held", 3'd0, 1'b0, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
